pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage CPU, the successor to the fixed EX/MEM latch. It carries a valid bit, a control-flag vector, two data words and a register write address through DEPTH back-to-back slices. It adds stall (hold), flush (bubble insertion) and control-kill-on-bubble behaviour. It is instantiated between any two pipeline stages (ID/EX, EX/MEM, MEM/WB) with per-instance widths.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/pipe_stage_slice.sv | 95 +++++++++
 rtl/pipe_stage_reg.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the inter-stage pipeline registers of the five-stage
// CPU:
//   - bit positions of the control flags carried alongside each instruction
//   - default payload widths used by every pipeline register instance
//   - a packed struct describing one slice payload at the default widths
//   - a saturating increment helper for 32-bit performance counters
//
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Control flag bit positions inside the ctrl vector.
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMREAD  = 2;
    localparam int unsigned CTRL_MEMWRITE = 3;

    // Default widths and depth limits for a pipeline register instance.
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_CTRL_W = 4;
    localparam int unsigned DEF_DEPTH  = 1;
    localparam int unsigned MAX_DEPTH  = 4;

    // Saturation value of the performance counters.
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // One slice payload at the default widths.
    typedef struct packed {
        logic                  valid;
        logic [DEF_CTRL_W-1:0] ctrl;
        logic [DEF_DATA_W-1:0] data0;
        logic [DEF_DATA_W-1:0] data1;
        logic [DEF_ADDR_W-1:0] waddr;
    } pipeSlice_t;

    // Increment cnt by one when inc is set, sticking at CNT_MAX.
    function automatic logic [31:0] satInc(input logic [31:0] cnt, input logic inc);
        return (inc && (cnt != CNT_MAX)) ? cnt + 32'd1 : cnt;
    endfunction

endpackage

// File: rtl/pipe_stage_slice.sv
// -----------------------------------------------------------------------------
// pipe_stage_slice
//
// One register slice of an inter-stage pipeline register. Each rising clock
// edge applies, in priority order:
//   rst_i   : clear every field
//   flush_i : clear valid and ctrl, keep data0/data1/waddr
//   stall_i : hold every field
//   else    : load the upstream fields
// A loaded bubble (valid_i = 0) always stores ctrl = 0, so a bubble can never
// assert a write enable further down the pipe.
//
// Ports:
//   clk_i      in   1       clock, rising edge
//   rst_i      in   1       synchronous active-high reset
//   stall_i    in   1       hold this slice
//   flush_i    in   1       turn this slice into a bubble
//   valid_i    in   1       upstream valid
//   ctrl_i     in   CTRL_W  upstream control flags
//   data0_i    in   DATA_W  upstream data word 0
//   data1_i    in   DATA_W  upstream data word 1
//   waddr_i    in   ADDR_W  upstream register write address
//   valid_o    out  1       registered valid
//   ctrl_o     out  CTRL_W  registered control flags
//   data0_o    out  DATA_W  registered data word 0
//   data1_o    out  DATA_W  registered data word 1
//   waddr_o    out  ADDR_W  registered write address
// -----------------------------------------------------------------------------
module pipe_stage_slice
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [ADDR_W-1:0] waddr_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data0_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [ADDR_W-1:0] waddr_o
);

    // Payload at this instance's widths.
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data0;
        logic [DATA_W-1:0] data1;
        logic [ADDR_W-1:0] waddr;
    } payload_t;

    payload_t sliceQ;
    payload_t sliceD;

    always_comb begin
        sliceD = sliceQ;
        if (flush_i) begin
            // Bubble insertion: data and waddr are left as they were.
            sliceD.valid = 1'b0;
            sliceD.ctrl  = '0;
        end else if (!stall_i) begin
            sliceD.valid = valid_i;
            // Control kill: a bubble never carries live control flags.
            sliceD.ctrl  = valid_i ? ctrl_i : '0;
            // Data and address load even for bubbles.
            sliceD.data0 = data0_i;
            sliceD.data1 = data1_i;
            sliceD.waddr = waddr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sliceQ <= '0;
        end else begin
            sliceQ <= sliceD;
        end
    end

    assign valid_o = sliceQ.valid;
    assign ctrl_o  = sliceQ.ctrl;
    assign data0_o = sliceQ.data0;
    assign data1_o = sliceQ.data1;
    assign waddr_o = sliceQ.waddr;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB). Carries a
// valid bit, a control-flag vector, two data words and a register write
// address through DEPTH (1..4) chained slices. All slices share the same
// per-cycle priority rst_i > flush_i > stall_i > advance. Outputs come straight
// from the last slice's flops; there is no combinational input-to-output path.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   defined   : stall_cnt_o counts cycles with stall_i=1, flush_i=0 and the
//               last slice valid; flush_cnt_o counts cycles with flush_i=1 and
//               any slice valid. Both saturate at 32'hFFFF_FFFF and clear on
//               rst_i.
//   undefined : both counter outputs are tied to 0 and no counter flops exist.
//
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       synchronous active-high reset
//   stall_i      in   1       hold all slices
//   flush_i      in   1       turn all slices into bubbles (beats stall_i)
//   valid_i      in   1       upstream instruction valid
//   ctrl_i       in   CTRL_W  upstream control flags
//   data0_i      in   DATA_W  upstream data word 0
//   data1_i      in   DATA_W  upstream data word 1
//   waddr_i      in   ADDR_W  upstream register write address
//   valid_o      out  1       last-slice valid
//   ctrl_o       out  CTRL_W  last-slice control flags
//   data0_o      out  DATA_W  last-slice data word 0
//   data1_o      out  DATA_W  last-slice data word 1
//   waddr_o      out  ADDR_W  last-slice write address
//   stall_cnt_o  out  32      stall performance counter
//   flush_cnt_o  out  32      flush performance counter
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned DEPTH  = DEF_DEPTH    // legal range 1..MAX_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [ADDR_W-1:0] waddr_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data0_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    // Chain element 0 is the upstream input, element k+1 is slice k's output.
    logic              validC [DEPTH+1];
    logic [CTRL_W-1:0] ctrlC  [DEPTH+1];
    logic [DATA_W-1:0] data0C [DEPTH+1];
    logic [DATA_W-1:0] data1C [DEPTH+1];
    logic [ADDR_W-1:0] waddrC [DEPTH+1];

    assign validC[0] = valid_i;
    assign ctrlC[0]  = ctrl_i;
    assign data0C[0] = data0_i;
    assign data1C[0] = data1_i;
    assign waddrC[0] = waddr_i;

    for (genvar k = 0; k < DEPTH; k++) begin : gSlice
        pipe_stage_slice #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .CTRL_W (CTRL_W)
        ) uSlice (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .stall_i (stall_i),
            .flush_i (flush_i),
            .valid_i (validC[k]),
            .ctrl_i  (ctrlC[k]),
            .data0_i (data0C[k]),
            .data1_i (data1C[k]),
            .waddr_i (waddrC[k]),
            .valid_o (validC[k+1]),
            .ctrl_o  (ctrlC[k+1]),
            .data0_o (data0C[k+1]),
            .data1_o (data1C[k+1]),
            .waddr_o (waddrC[k+1])
        );
    end

    assign valid_o = validC[DEPTH];
    assign ctrl_o  = ctrlC[DEPTH];
    assign data0_o = data0C[DEPTH];
    assign data1_o = data1C[DEPTH];
    assign waddr_o = waddrC[DEPTH];

`ifdef PIPE_STAGE_PERF_EN
    logic [DEPTH-1:0] sliceValid;
    logic             anyValid;
    logic             stallInc;
    logic             flushInc;
    logic [31:0]      stallCntQ;
    logic [31:0]      stallCntD;
    logic [31:0]      flushCntQ;
    logic [31:0]      flushCntD;

    for (genvar k = 0; k < DEPTH; k++) begin : gSliceValid
        assign sliceValid[k] = validC[k+1];
    end

    assign anyValid = |sliceValid;

    // A stall only costs a cycle when there is a real instruction at the end.
    assign stallInc = stall_i && !flush_i && validC[DEPTH];
    // A flush is only interesting when it actually squashes something.
    assign flushInc = flush_i && anyValid;

    always_comb begin
        stallCntD = satInc(stallCntQ, stallInc);
        flushCntD = satInc(flushCntQ, flushInc);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            stallCntQ <= stallCntD;
            flushCntQ <= flushCntD;
        end
    end

    assign stall_cnt_o = stallCntQ;
    assign flush_cnt_o = flushCntQ;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Drives three pipe_stage_reg instances (DEPTH 1, 2 and 4) with the same
// directed stimulus. A queue-style model of an in-order pipeline predicts the
// outputs and is compared on every falling edge; hand-computed literal checks
// pin the model at the key points.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
    import pipe_pkg::*;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, vIn;
    logic [3:0]  cIn;
    logic [31:0] d0In, d1In;
    logic [4:0]  waIn;

    logic        oValid [NDUT];
    logic [3:0]  oCtrl  [NDUT];
    logic [31:0] oData0 [NDUT];
    logic [31:0] oData1 [NDUT];
    logic [4:0]  oWaddr [NDUT];
    logic [31:0] oStall [NDUT];
    logic [31:0] oFlush [NDUT];

    pipe_stage_reg #(.DATA_W(32), .ADDR_W(5), .CTRL_W(4), .DEPTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .valid_i(vIn), .ctrl_i(cIn), .data0_i(d0In), .data1_i(d1In), .waddr_i(waIn),
        .valid_o(oValid[0]), .ctrl_o(oCtrl[0]), .data0_o(oData0[0]), .data1_o(oData1[0]),
        .waddr_o(oWaddr[0]), .stall_cnt_o(oStall[0]), .flush_cnt_o(oFlush[0])
    );

    pipe_stage_reg #(.DATA_W(32), .ADDR_W(5), .CTRL_W(4), .DEPTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .valid_i(vIn), .ctrl_i(cIn), .data0_i(d0In), .data1_i(d1In), .waddr_i(waIn),
        .valid_o(oValid[1]), .ctrl_o(oCtrl[1]), .data0_o(oData0[1]), .data1_o(oData1[1]),
        .waddr_o(oWaddr[1]), .stall_cnt_o(oStall[1]), .flush_cnt_o(oFlush[1])
    );

    pipe_stage_reg #(.DATA_W(32), .ADDR_W(5), .CTRL_W(4), .DEPTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .valid_i(vIn), .ctrl_i(cIn), .data0_i(d0In), .data1_i(d1In), .waddr_i(waIn),
        .valid_o(oValid[2]), .ctrl_o(oCtrl[2]), .data0_o(oData0[2]), .data1_o(oData1[2]),
        .waddr_o(oWaddr[2]), .stall_cnt_o(oStall[2]), .flush_cnt_o(oFlush[2])
    );

    int nTests = 0;
    int nFail  = 0;
    bit started = 1'b0;

    // Model: per DUT, the in-flight entries oldest-last plus the two counters.
    pipeSlice_t  mdl    [NDUT][4];
    logic [31:0] mStall [NDUT];
    logic [31:0] mFlush [NDUT];

    function automatic int dep(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelStep();
        for (int d = 0; d < NDUT; d++) begin
            int n;
            bit anyV;
            n = dep(d);
            if (rst) begin
                for (int k = 0; k < 4; k++) mdl[d][k] = '0;
                mStall[d] = 32'd0;
                mFlush[d] = 32'd0;
            end else if (flush) begin
                anyV = 1'b0;
                for (int k = 0; k < n; k++) anyV |= mdl[d][k].valid;
                if (anyV && mFlush[d] != 32'hFFFF_FFFF) mFlush[d] = mFlush[d] + 32'd1;
                for (int k = 0; k < n; k++) begin
                    mdl[d][k].valid = 1'b0;
                    mdl[d][k].ctrl  = 4'h0;
                end
            end else if (stall) begin
                if (mdl[d][n-1].valid && mStall[d] != 32'hFFFF_FFFF)
                    mStall[d] = mStall[d] + 32'd1;
            end else begin
                for (int k = n - 1; k > 0; k--) mdl[d][k] = mdl[d][k-1];
                mdl[d][0].valid = vIn;
                mdl[d][0].ctrl  = vIn ? cIn : 4'h0;
                mdl[d][0].data0 = d0In;
                mdl[d][0].data1 = d1In;
                mdl[d][0].waddr = waIn;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        #2;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [4:0] wa);
        vIn = v; cIn = c; d0In = d0; d1In = d1; waIn = wa;
    endtask

    // Compare every DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < NDUT; d++) begin
                pipeSlice_t e;
                e = mdl[d][dep(d)-1];
                check($sformatf("d%0d_valid", dep(d)), {31'd0, oValid[d]}, {31'd0, e.valid});
                check($sformatf("d%0d_ctrl", dep(d)), {28'd0, oCtrl[d]}, {28'd0, e.ctrl});
                check($sformatf("d%0d_data0", dep(d)), oData0[d], e.data0);
                check($sformatf("d%0d_data1", dep(d)), oData1[d], e.data1);
                check($sformatf("d%0d_waddr", dep(d)), {27'd0, oWaddr[d]}, {27'd0, e.waddr});
                check($sformatf("d%0d_stall_cnt", dep(d)), oStall[d], PERF ? mStall[d] : 32'd0);
                check($sformatf("d%0d_flush_cnt", dep(d)), oFlush[d], PERF ? mFlush[d] : 32'd0);
            end
        end
    end

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        v;
        logic [3:0]  c;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [4:0]  wa;
    } vec_t;

    vec_t vecs [14];

    task automatic checkAllZero(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s_d%0d_valid", tag, dep(d)), {31'd0, oValid[d]}, 32'd0);
            check($sformatf("%s_d%0d_ctrl", tag, dep(d)), {28'd0, oCtrl[d]}, 32'd0);
            check($sformatf("%s_d%0d_data0", tag, dep(d)), oData0[d], 32'd0);
            check($sformatf("%s_d%0d_data1", tag, dep(d)), oData1[d], 32'd0);
            check($sformatf("%s_d%0d_waddr", tag, dep(d)), {27'd0, oWaddr[d]}, 32'd0);
            check($sformatf("%s_d%0d_scnt", tag, dep(d)), oStall[d], 32'd0);
            check($sformatf("%s_d%0d_fcnt", tag, dep(d)), oFlush[d], 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 32'h0000_0101, 32'h0000_1001, 5'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 32'h0000_0202, 32'h0000_2002, 5'd2};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0303, 32'h0000_3003, 5'd3};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 32'h0000_0404, 32'h0000_4004, 5'd4};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h8, 32'h0000_0505, 32'h0000_5005, 5'd5};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h8, 32'h0000_0555, 32'h0000_5555, 5'd5};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h8, 32'h0000_0606, 32'h0000_6006, 5'd6};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0000_0707, 32'h0000_7007, 5'd7};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0808, 32'h0000_8008, 5'd8};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0909, 32'h0000_9009, 5'd9};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 32'h0000_0A0A, 32'h0000_A00A, 5'd10};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 32'h0000_0B0B, 32'h0000_B00B, 5'd11};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 32'h0000_0C0C, 32'h0000_C00C, 5'd12};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0D0D, 32'h0000_D00D, 5'd13};

        // Reset with nonzero inputs present.
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 4'hF, 32'hFFFF_0000, 32'h0000_FFFF, 5'd31);
        step();
        checkAllZero("reset");
        started = 1'b1;
        rst = 1'b0;

        // Pass-through.
        drive(1'b1, 4'b1001, 32'h1234_5678, 32'hCAFE_F00D, 5'd7);
        step();
        check("pass_d1_valid", {31'd0, oValid[0]}, 32'd1);
        check("pass_d1_data0", oData0[0], 32'h1234_5678);
        drive(1'b0, 4'b1111, 32'hDEAD_0001, 32'h0, 5'd3);
        step();
        check("pass_d2_valid", {31'd0, oValid[1]}, 32'd1);
        check("pass_d2_ctrl", {28'd0, oCtrl[1]}, 32'h9);
        check("pass_d2_data0", oData0[1], 32'h1234_5678);
        check("pass_d2_data1", oData1[1], 32'hCAFE_F00D);
        check("pass_d2_waddr", {27'd0, oWaddr[1]}, 32'd7);
        check("kill_d1_ctrl", {28'd0, oCtrl[0]}, 32'h0);
        check("kill_d1_data0", oData0[0], 32'hDEAD_0001);
        step();
        check("kill_d2_ctrl", {28'd0, oCtrl[1]}, 32'h0);
        check("kill_d2_valid", {31'd0, oValid[1]}, 32'd0);
        check("kill_d2_waddr", {27'd0, oWaddr[1]}, 32'd3);

        // Stall for three cycles while the inputs change.
        drive(1'b1, 4'b0001, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd9);
        step();
        check("stall_load_d1", oData0[0], 32'hA5A5_A5A5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i), 32'h1111_1111 * (i + 1), 32'h2222_2222, 5'(i));
            step();
            check($sformatf("stall_hold_%0d", i), oData0[0], 32'hA5A5_A5A5);
        end
        check("stall_cnt_3", oStall[0], PERF ? 32'd3 : 32'd0);

        // Flush together with stall on a held valid entry.
        flush = 1'b1;
        step();
        check("flush_valid", {31'd0, oValid[0]}, 32'd0);
        check("flush_ctrl", {28'd0, oCtrl[0]}, 32'd0);
        check("flush_data0", oData0[0], 32'hA5A5_A5A5);
        check("flush_cnt_1", oFlush[0], PERF ? 32'd1 : 32'd0);
        flush = 1'b0;
        stall = 1'b0;

        // Directed vector sequence, checked against the model.
        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
            drive(vecs[i].v, vecs[i].c, vecs[i].d0, vecs[i].d1, vecs[i].wa);
            step();
        end

        // Reset mid-operation, with stall, flush and a valid input all active.
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 4'h5, 32'h7777_0001, 32'h7777_0002, 5'd17);
        step();
        step();
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        step();
        checkAllZero("midrst");
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        // Saturation of the stall counter.
        drive(1'b1, 4'h1, 32'h0BAD_BEEF, 32'h0, 5'd1);
        step();
        stall = 1'b1;
        force dut1.stallCntQ = 32'hFFFF_FFFE;
        mStall[0] = 32'hFFFF_FFFE;
        #1;
        release dut1.stallCntQ;
        for (int i = 0; i < 3; i++) step();
        check("stall_cnt_sat", oStall[0], 32'hFFFF_FFFF);
        stall = 1'b0;
`endif

        step();
        step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
